// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational ROM and buffers
// fetched words in a small FIFO presented to decode over valid/ready.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2,
    parameter int unsigned PTR_W    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [31:0]      rom_addr,
    input  logic [31:0]      rom_inst,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    input  logic             inst_ready,
    output logic [PTR_W:0]   q_count,
    output logic             misalign
);

    localparam logic [PTR_W:0] QDepthCnt = QDEPTH[PTR_W:0];

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             mis_q, mis_d;
    logic [31:0]      inst_mem_q [QDEPTH];
    logic [31:0]      inst_mem_d [QDEPTH];
    logic [31:0]      pc_mem_q   [QDEPTH];
    logic [31:0]      pc_mem_d   [QDEPTH];
    logic             pop;
    logic             push;

    assign rom_addr   = pc_q;
    assign inst_valid = (cnt_q != '0);
    assign inst       = inst_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];
    assign q_count    = cnt_q;
    assign misalign   = mis_q;

    always_comb begin
        pop        = inst_valid & inst_ready;
        // A full queue can still accept when the head leaves in the same cycle.
        push       = run & ~redirect_valid & ((cnt_q < QDepthCnt) | pop);
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mis_d      = 1'b0;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;

        if (redirect_valid) begin
            // Flush discards any pop in this cycle along with the stale entries.
            pc_d     = {redirect_target[31:2], 2'b00};
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            mis_d    = |redirect_target[1:0];
        end else begin
            if (push) begin
                inst_mem_d[wr_ptr_q] = rom_inst;
                pc_mem_d[wr_ptr_q]   = pc_q;
                wr_ptr_d             = wr_ptr_q + 1'b1;
                pc_d                 = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            mis_q    <= 1'b0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mis_q      <= mis_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed vector table, reset corner cases, and
// randomized traffic checked against a queue-based reference model.
module tb_inst_fetch_ctrl;

    localparam int QD = 2;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [1:0]  q_count;
    logic        misalign;

    logic [31:0] rom [32];
    assign rom_inst = rom[rom_addr[6:2]];

    int n_cmp = 0;
    int n_err = 0;

    inst_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QD),
        .PTR_W    (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run),
        .rom_addr        (rom_addr),
        .rom_inst        (rom_inst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .q_count         (q_count),
        .misalign        (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        ev;
        logic [1:0]  cnt;
        logic [31:0] hpc;
        logic        mis;
        logic [31:0] ra;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    vec_t        tbl [18];
    ent_t        mq [$];
    logic [31:0] mpc;
    logic        mmis;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " rom_addr"}, rom_addr, 32'h0);
        check({tag, " inst_valid"}, {31'b0, inst_valid}, 32'h0);
        check({tag, " inst"}, inst, 32'h0);
        check({tag, " inst_pc"}, inst_pc, 32'h0);
        check({tag, " q_count"}, {30'b0, q_count}, 32'h0);
        check({tag, " misalign"}, {31'b0, misalign}, 32'h0);
    endtask

    task automatic drive(input logic r, input logic rd, input logic rv, input logic [31:0] t);
        run             = r;
        inst_ready      = rd;
        redirect_valid  = rv;
        redirect_target = t;
    endtask

    task automatic reset_release();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        mpc  = 32'h0;
        mmis = 1'b0;
    endtask

    // Reference: queue of {pc, word}; redirect wins, else pop then push if room.
    task automatic model_step();
        logic pop;
        logic push;
        pop = (mq.size() != 0) && inst_ready;
        if (redirect_valid) begin
            mq.delete();
            mpc  = {redirect_target[31:2], 2'b00};
            mmis = (redirect_target[1:0] != 2'b00);
        end else begin
            mmis = 1'b0;
            push = run && ((mq.size() < QD) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{mpc, rom[mpc[6:2]]});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic model_compare();
        check("rnd rom_addr", rom_addr, mpc);
        check("rnd inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
        check("rnd q_count", {30'b0, q_count}, 32'(mq.size()));
        check("rnd misalign", {31'b0, misalign}, {31'b0, mmis});
        if (mq.size() != 0) begin
            check("rnd inst_pc", inst_pc, mq[0].pc);
            check("rnd inst", inst, mq[0].ins);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 + 32'(i + 1);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk_zero("reset");
        reset_release();
        check("post-release rom_addr", rom_addr, 32'h0);

        //            run   rdy   rv    tgt           ev    cnt   hpc           mis   ra
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 2'd1, 32'h00, 1'b0, 32'h04};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 2'd1, 32'h04, 1'b0, 32'h08};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 2'd1, 32'h08, 1'b0, 32'h0C};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 2'd2, 32'h08, 1'b0, 32'h10};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 2'd2, 32'h08, 1'b0, 32'h10};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 2'd2, 32'h08, 1'b0, 32'h10};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 2'd2, 32'h0C, 1'b0, 32'h14};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 2'd2, 32'h10, 1'b0, 32'h18};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 2'd0, 32'h00, 1'b0, 32'h20};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 2'd1, 32'h20, 1'b0, 32'h24};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h13, 1'b0, 2'd0, 32'h00, 1'b1, 32'h10};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 2'd1, 32'h10, 1'b0, 32'h14};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h7C, 1'b0, 2'd0, 32'h00, 1'b0, 32'h7C};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 2'd1, 32'h7C, 1'b0, 32'h80};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 2'd1, 32'h80, 1'b0, 32'h84};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 2'd0, 32'h00, 1'b0, 32'h84};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 2'd0, 32'h00, 1'b0, 32'h40};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 2'd0, 32'h00, 1'b0, 32'h40};

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].run, tbl[i].rdy, tbl[i].rv, tbl[i].tgt);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].ev});
            check($sformatf("vec%0d q_count", i), {30'b0, q_count}, {30'b0, tbl[i].cnt});
            check($sformatf("vec%0d misalign", i), {31'b0, misalign}, {31'b0, tbl[i].mis});
            check($sformatf("vec%0d rom_addr", i), rom_addr, tbl[i].ra);
            if (tbl[i].ev) begin
                check($sformatf("vec%0d inst_pc", i), inst_pc, tbl[i].hpc);
                check($sformatf("vec%0d inst", i), inst, rom[tbl[i].hpc[6:2]]);
            end
            @(negedge clk);
        end

        // Fill the queue, then reset together with a redirect before any edge.
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("fill q_count", {30'b0, q_count}, 32'd2);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h13);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        reset_release();

        // A pending misalign pulse must vanish on reset.
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0013);
        @(posedge clk);
        #1;
        check("mis pulse", {31'b0, misalign}, 32'd1);
        check("mis pc", rom_addr, 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("misreset");
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        reset_release();

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                            : $urandom;
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 15) == 0), t);
            model_step();
            @(posedge clk);
            #1;
            model_compare();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the single-cycle MIPS core.
- Owns the program counter and drives the address of the combinational instruction ROM (32 words, word index addr[6:2]).
- Buffers fetched words in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QDEPTH, 2, instruction queue depth in entries (power of two, 2..8).
- PTR_W, 1, log2(QDEPTH); set by the integrator together with QDEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  fetch enable; 0 freezes the PC and stops enqueues; the queue still drains.
- rom_addr  out  32  address to the instruction ROM; always equals the PC.
- rom_inst  in  32  ROM data for rom_addr, valid in the same cycle.
- redirect_valid  in  1  one-cycle request to change the PC.
- redirect_target  in  32  new PC; bits [1:0] are ignored.
- inst_valid  out  1  queue head is valid.
- inst  out  32  queue-head instruction.
- inst_pc  out  32  PC of the queue-head instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- q_count  out  PTR_W+1  number of occupied queue entries.
- misalign  out  1  one-cycle pulse when redirect_target[1:0] != 0.

Behaviour:
- Reset (async assert, sync release is the integrator's concern):
  - pc = RESET_PC; queue empty.
  - inst_valid = 0, q_count = 0, misalign = 0.
  - inst and inst_pc = 0.
- Combinational outputs: rom_addr = pc; inst_valid = (q_count != 0); inst/inst_pc come from the head entry.
- pop = inst_valid & inst_ready.
- push = run & ~redirect_valid & (q_count < QDEPTH | pop).
  - Push into a full queue is allowed only when a pop occurs in the same cycle.
- On push:
  - Write {pc, rom_inst} at the tail.
  - pc <= pc + 4, full 32-bit add with natural wrap at 2^32.
  - ROM aliasing every 128 bytes is expected and is not an error.
- Redirect (highest priority):
  - On a clock edge with redirect_valid=1: pc <= {redirect_target[31:2], 2'b00}.
  - The queue is flushed: q_count <= 0, read and write pointers reset to 0.
  - No push occurs that cycle; any pop that cycle is discarded with the flush.
  - Decode must treat a handshake in the redirect cycle as void.
  - misalign is registered: it pulses high the cycle after a redirect with target[1:0] != 0.
  - A redirect while run=0 still updates the PC and flushes.
- Count update (non-redirect cycles):
  - push & ~pop: +1.
  - pop & ~push: -1.
  - Both or neither: unchanged.
- Latency:
  - An instruction at PC X is visible on inst/inst_pc in the cycle after the edge on which it was pushed.
  - The first instruction after reset appears 1 cycle after reset release with run=1.
  - After a redirect, the first instruction at the target appears 2 edges after the redirect edge: one edge to load the PC, one to push.
- Throughput: one instruction per cycle when inst_ready is held high.
- FIFO behaviour:
  - Pointers wrap modulo QDEPTH.
  - The head entry is stable while inst_valid=1 and inst_ready=0.
- Stall: with run=1 and the queue full with no pop, the PC holds and rom_addr is constant.
- Reset mid-operation discards all state immediately, including the queue and a pending misalign pulse.

Test Plan:
- Reset, then run=1, inst_ready=1, ROM preloaded with words 1..11 -> inst_pc sequence 0x00,0x04,0x08,… one per cycle; inst matches ROM; q_count stays at 1.
- run=1, inst_ready=0 for 5 cycles -> q_count reaches 2 and holds; pc freezes at 0x08; head stays at PC 0x00. Then inst_ready=1 -> the order 0x00,0x04,0x08 is preserved with no gap or duplicate.
- Redirect to 0x0000_0020 while queue holds 2 entries and inst_ready=1 -> next cycle q_count=0, inst_valid=0; then inst_pc=0x20 and inst=ROM[8]; misalign stays 0.
- Redirect to 0x0000_0013 -> pc=0x10; misalign pulses exactly one cycle; first delivered inst_pc=0x10.
- pc driven to 0x7C with run=1 -> pushes 0x7C then 0x80; rom_addr[6:2] wraps to 0, so the instruction at 0x80 equals ROM[0]; no stall.
- Assert rst_n=0 mid-stream with queue full and redirect_valid=1 in the same cycle -> all outputs are 0 and pc=RESET_PC immediately, before the next clock edge.
